// File: rtl/encode_opnds_pkg.sv
// Shared constants, operand-form codes and FSM state encoding for the x86 instruction encoder.
package encode_opnds_pkg;

   localparam int unsigned ENC_MAX_LEN = 9;

   localparam logic [3:0] OPND_ENC_NONE                = 4'd0;
   localparam logic [3:0] OPND_ENC_REG                 = 4'd1;
   localparam logic [3:0] OPND_ENC_IMM                 = 4'd2;
   localparam logic [3:0] OPND_ENC_MODREGRM_RM         = 4'd3;
   localparam logic [3:0] OPND_ENC_MODREGRM_RM_IMM     = 4'd4;
   localparam logic [3:0] OPND_ENC_REG_IMM             = 4'd5;
   localparam logic [3:0] OPND_ENC_EAX_IMM             = 4'd6;
   localparam logic [3:0] OPND_ENC_EAX_REG             = 4'd7;
   localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM     = 4'd8;
   localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG     = 4'd9;
   localparam logic [3:0] OPND_ENC_MODREGRM_REG_RM_IMM = 4'd10;
   localparam logic [3:0] OPND_ENC_MODREGRM_RM_REG_IMM = 4'd11;

   typedef enum logic [2:0] {
      StIdle, StOpc, StModrm, StSib, StDisp, StImm, StFin
   } enc_state_e;

   function automatic logic form_valid(logic [3:0] form);
      return form <= OPND_ENC_MODREGRM_RM_REG_IMM;
   endfunction

   function automatic logic form_has_modrm(logic [3:0] form);
      return form inside {OPND_ENC_MODREGRM_RM, OPND_ENC_MODREGRM_RM_IMM,
                          OPND_ENC_MODREGRM_REG_RM, OPND_ENC_MODREGRM_RM_REG,
                          OPND_ENC_MODREGRM_REG_RM_IMM, OPND_ENC_MODREGRM_RM_REG_IMM};
   endfunction

   function automatic logic form_has_imm(logic [3:0] form);
      return form inside {OPND_ENC_IMM, OPND_ENC_MODREGRM_RM_IMM, OPND_ENC_REG_IMM,
                          OPND_ENC_EAX_IMM, OPND_ENC_MODREGRM_REG_RM_IMM,
                          OPND_ENC_MODREGRM_RM_REG_IMM};
   endfunction

   // Register number folded into the low three opcode bits.
   function automatic logic form_reg_in_opc(logic [3:0] form);
      return form inside {OPND_ENC_REG, OPND_ENC_REG_IMM, OPND_ENC_EAX_REG};
   endfunction

endpackage

// File: rtl/encode_len.sv
// Field presence and total length of one encoded instruction; purely combinational.
module encode_len
   import encode_opnds_pkg::*;
#(
   parameter int unsigned MAX_LEN = ENC_MAX_LEN
) (
   input  logic [3:0] form,
   input  logic [1:0] mod,
   input  logic [2:0] rm,
   input  logic       imm_1byte,
   input  logic       op16,
   input  logic       addr16,
   output logic       has_modrm,
   output logic       has_sib,
   output logic [2:0] disp_len,
   output logic [2:0] imm_len,
   output logic [3:0] total,
   output logic       err
);

   always_comb begin
      has_modrm = form_has_modrm(form);
      has_sib   = has_modrm && !addr16 && (mod != 2'b11) && (rm == 3'b100);
      disp_len  = 3'd0;
      if (has_modrm) begin
         if (mod == 2'b01) begin
            disp_len = 3'd1;
         end else if ((mod == 2'b10) || ((mod == 2'b00) && (rm == 3'b101))) begin
            disp_len = addr16 ? 3'd2 : 3'd4;
         end
      end
      imm_len = 3'd0;
      if (form_has_imm(form)) begin
         imm_len = imm_1byte ? 3'd1 : (op16 ? 3'd2 : 3'd4);
      end
      total = 4'd1 + {3'b000, has_modrm} + {3'b000, has_sib} + {1'b0, disp_len}
            + {1'b0, imm_len};
      err   = !form_valid(form) || (32'(total) > MAX_LEN);
   end

endmodule

// File: rtl/encode_opnds.sv
// Serializing x86 instruction encoder: one request in, instruction bytes out one per cycle,
// then the whole instruction as a packed window plus length.
module encode_opnds
   import encode_opnds_pkg::*;
#(
   parameter int unsigned MAX_LEN = ENC_MAX_LEN
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [7:0]             req_opc,
   input  logic [3:0]             req_form,
   input  logic [1:0]             req_mod,
   input  logic [2:0]             req_reg,
   input  logic [2:0]             req_rm,
   input  logic [7:0]             req_sib,
   input  logic [31:0]            req_disp,
   input  logic [31:0]            req_imm,
   input  logic                   req_imm_1byte,
   input  logic                   req_op16,
   input  logic                   req_addr16,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [7:0]             out_byte,
   output logic                   out_last,
   output logic                   done,
   output logic                   err,
   output logic [8*MAX_LEN-1:0]   instr_window,
   output logic [3:0]             instr_len
);

   localparam int unsigned WinW = 8 * MAX_LEN;

   enc_state_e state_q, state_d;
   logic [7:0]  opc_q, sib_q;
   logic [3:0]  form_q;
   logic [1:0]  mod_q;
   logic [2:0]  reg_q, rm_q;
   logic [31:0] disp_q, imm_q;
   logic        imm_1byte_q, op16_q, addr16_q;
   logic [1:0]  fcnt_q, fcnt_d;
   logic [3:0]  idx_q;
   logic [WinW-1:0] acc_q, acc_upd;

   logic        idle, accept, hs;
   logic        has_modrm, has_sib, len_err;
   logic [2:0]  disp_len, imm_len;
   logic [3:0]  len;
   enc_state_e  nxt_after_disp, nxt_after_sib, nxt_after_modrm, nxt_after_opc;

   assign idle      = (state_q == StIdle);
   assign accept    = idle && req_valid;
   assign req_ready = idle;
   assign done      = (state_q == StFin);
   assign err       = done && len_err;

   // Live request while idle so accept can branch on errors; registered copy once busy.
   encode_len #(
      .MAX_LEN (MAX_LEN)
   ) u_len (
      .form      (idle ? req_form      : form_q),
      .mod       (idle ? req_mod       : mod_q),
      .rm        (idle ? req_rm        : rm_q),
      .imm_1byte (idle ? req_imm_1byte : imm_1byte_q),
      .op16      (idle ? req_op16      : op16_q),
      .addr16    (idle ? req_addr16    : addr16_q),
      .has_modrm (has_modrm),
      .has_sib   (has_sib),
      .disp_len  (disp_len),
      .imm_len   (imm_len),
      .total     (len),
      .err       (len_err)
   );

   always_comb begin
      out_valid = 1'b0;
      out_byte  = 8'h00;
      unique case (state_q)
         StOpc: begin
            out_valid = 1'b1;
            out_byte  = form_reg_in_opc(form_q) ? {opc_q[7:3], reg_q} : opc_q;
         end
         StModrm: begin
            out_valid = 1'b1;
            out_byte  = {mod_q, reg_q, rm_q};
         end
         StSib: begin
            out_valid = 1'b1;
            out_byte  = sib_q;
         end
         StDisp: begin
            out_valid = 1'b1;
            out_byte  = disp_q[8*fcnt_q +: 8];
         end
         StImm: begin
            out_valid = 1'b1;
            out_byte  = imm_q[8*fcnt_q +: 8];
         end
         default: ;
      endcase
      out_last = out_valid && (idx_q == (len - 4'd1));
      hs       = out_valid && out_ready;
   end

   always_comb begin
      acc_upd = acc_q;
      if (32'(idx_q) < MAX_LEN) begin
         acc_upd[8*idx_q +: 8] = out_byte;
      end
   end

   always_comb begin
      nxt_after_disp  = (imm_len != 3'd0) ? StImm : StFin;
      nxt_after_sib   = (disp_len != 3'd0) ? StDisp : nxt_after_disp;
      nxt_after_modrm = has_sib ? StSib : nxt_after_sib;
      nxt_after_opc   = has_modrm ? StModrm : nxt_after_disp;

      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         StIdle:  if (req_valid) state_d = len_err ? StFin : StOpc;
         StOpc:   if (hs) state_d = nxt_after_opc;
         StModrm: if (hs) state_d = nxt_after_modrm;
         StSib:   if (hs) state_d = nxt_after_sib;
         StDisp: begin
            if (hs) begin
               if ({1'b0, fcnt_q} == (disp_len - 3'd1)) begin
                  state_d = nxt_after_disp;
                  fcnt_d  = 2'd0;
               end else begin
                  fcnt_d = fcnt_q + 2'd1;
               end
            end
         end
         StImm: begin
            if (hs) begin
               if ({1'b0, fcnt_q} == (imm_len - 3'd1)) begin
                  state_d = StFin;
                  fcnt_d  = 2'd0;
               end else begin
                  fcnt_d = fcnt_q + 2'd1;
               end
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         opc_q        <= '0;
         form_q       <= '0;
         mod_q        <= '0;
         reg_q        <= '0;
         rm_q         <= '0;
         sib_q        <= '0;
         disp_q       <= '0;
         imm_q        <= '0;
         imm_1byte_q  <= 1'b0;
         op16_q       <= 1'b0;
         addr16_q     <= 1'b0;
         fcnt_q       <= '0;
         idx_q        <= '0;
         acc_q        <= '0;
         instr_window <= '0;
         instr_len    <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         if (accept) begin
            opc_q       <= req_opc;
            form_q      <= req_form;
            mod_q       <= req_mod;
            reg_q       <= req_reg;
            rm_q        <= req_rm;
            sib_q       <= req_sib;
            disp_q      <= req_disp;
            imm_q       <= req_imm;
            imm_1byte_q <= req_imm_1byte;
            op16_q      <= req_op16;
            addr16_q    <= req_addr16;
            idx_q       <= '0;
            acc_q       <= '0;
         end else if (hs) begin
            idx_q <= idx_q + 4'd1;
            acc_q <= acc_upd;
         end
         // Publish on the edge into FIN so the values are visible alongside done.
         if ((state_d == StFin) && (state_q != StFin)) begin
            instr_window <= len_err ? '0 : acc_upd;
            instr_len    <= len_err ? 4'd0 : len;
         end
      end
   end

endmodule
